// File: rtl/axil_bram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// axil_bram_stream_reader_if
//   Bundles the AXI-Lite read channels (toward the BRAM port) and the
//   AXI-Stream output of axil_bram_stream_reader.
//   Signal names keep their original m_axil_* / m_axis_* spelling.
//   modport master : the reader (drives AR, R-ready, stream)
//   modport slave  : the BRAM read port plus the stream consumer
// ---------------------------------------------------------------------------
interface axil_bram_stream_reader_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_axil_araddr;
  logic [2:0]            m_axil_arprot;
  logic                  m_axil_arvalid;
  logic                  m_axil_arready;
  logic [DATA_WIDTH-1:0] m_axil_rdata;
  logic [1:0]            m_axil_rresp;
  logic                  m_axil_rvalid;
  logic                  m_axil_rready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;

  modport master (
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    input  m_axil_arready,
    input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    output m_axil_rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    input  m_axil_rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/axil_bram_stream_reader.sv
// ---------------------------------------------------------------------------
// axil_bram_stream_reader
//   AXI-Lite read master that drains a contiguous word range from a BRAM
//   port and re-emits it as an AXI-Stream burst (tlast on the final word).
//   One read outstanding at a time; a single-entry output register holds
//   each word until the stream accepts it.
//
// Ports
//   clka        clock
//   rstb        synchronous active-high reset (shared with the BRAM port)
//   start       begin burst, sampled only while idle
//   base_addr   first byte address (forced word aligned)
//   word_count  words to read, 0 = empty burst (done only, no traffic)
//   busy        high from accepted start until done
//   done        one-cycle completion pulse
//   err         sticky read-error flag (see macro below)
//   bus         axil_bram_stream_reader_if.master: AR/R channels + stream
//
// Build option
//   AXIL_READER_RRESP_CHECK_EN : when defined, err is set by any accepted
//   R beat with rresp != OKAY, cleared by reset or an accepted start; the
//   erroring data is still streamed. When undefined err is tied low.
// ---------------------------------------------------------------------------
module axil_bram_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  axil_bram_stream_reader_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(STRB_WIDTH);

  typedef enum logic [1:0] {IDLE, AR, R, FLUSH} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  rready;
  logic                  r_fire;
  logic                  t_fire;

  // Accept read data only when the output register is empty or draining
  // this cycle, so a held stream word is never overwritten.
  assign rready = (state == R) && (!tvalid || bus.m_axis_tready);
  assign r_fire = bus.m_axil_rvalid && rready;
  assign t_fire = tvalid && bus.m_axis_tready;

  always_ff @(posedge clka) begin
    if (rstb) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      tdata     <= '0;
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Drain by default; a new beat loaded in R below takes priority.
      if (t_fire) begin
        tvalid <= 1'b0;
        tlast  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr & ALIGN_MASK;
            remaining <= word_count;
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              state   <= AR;
              busy    <= 1'b1;
              arvalid <= 1'b1;
              araddr  <= base_addr & ALIGN_MASK;
            end
          end
        end
        AR: begin
          if (arvalid && bus.m_axil_arready) begin
            arvalid <= 1'b0;
            addr    <= addr + ADDR_STEP;
            state   <= R;
          end
        end
        R: begin
          if (r_fire) begin
            tdata     <= bus.m_axil_rdata;
            tvalid    <= 1'b1;
            tlast     <= (remaining == CNT_WIDTH'(1));
            remaining <= remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
              state <= FLUSH;
            end else begin
              state   <= AR;
              arvalid <= 1'b1;
              araddr  <= addr;
            end
          end
        end
        FLUSH: begin
          if (t_fire) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef AXIL_READER_RRESP_CHECK_EN
  always_ff @(posedge clka) begin
    if (rstb) begin
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      err <= 1'b0;
    end else if (r_fire && bus.m_axil_rresp != 2'b00) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign bus.m_axil_araddr  = araddr;
  assign bus.m_axil_arprot  = 3'b000;
  assign bus.m_axil_arvalid = arvalid;
  assign bus.m_axil_rready  = rready;
  assign bus.m_axis_tdata   = tdata;
  assign bus.m_axis_tvalid  = tvalid;
  assign bus.m_axis_tlast   = tlast;

endmodule

// File: tb/tb_axil_bram_stream_reader.sv
module tb_axil_bram_stream_reader;
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 8;
  localparam int unsigned WORDS = 128;

  logic          clka = 1'b0;
  logic          rstb = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done, err;

  axil_bram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_bram_stream_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(4), .CNT_WIDTH(CW)
  ) dut (
    .clka(clka), .rstb(rstb), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .err(err),
    .bus(bus.master)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic [DW-1:0] mem [WORDS];
  beat_t         exp_q[$];
  logic [AW-1:0] exp_ar_q[$];
  logic [AW-1:0] rd_q[$];

  int mode = 0;          // 0: immediate ready/valid, 1: random
  int tready_manual = 0;
  int err_beat = -1;
  int beat_idx = 0;
  int outstanding = 0;
  int t_count = 0;

  logic          ar_fire_s = 1'b0, r_fire_s = 1'b0, t_fire_s = 1'b0;
  logic [AW-1:0] ar_addr_s = '0;
  logic          prev_tvalid = 1'b0, prev_tready = 1'b0;
  logic [DW-1:0] prev_tdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: samples at negedge, where everything is settled.
  initial begin
    forever begin
      @(negedge clka);
      ar_fire_s = bus.m_axil_arvalid && bus.m_axil_arready;
      r_fire_s  = bus.m_axil_rvalid && bus.m_axil_rready;
      t_fire_s  = bus.m_axis_tvalid && bus.m_axis_tready;
      ar_addr_s = bus.m_axil_araddr;
      if (rstb) begin
        prev_tvalid = 1'b0;
      end else begin
        if (bus.m_axil_arvalid) check("single_outstanding", outstanding, 0);
        if (ar_fire_s) begin
          check("ar_expected", exp_ar_q.size() > 0, 1);
          if (exp_ar_q.size() > 0) check("araddr", ar_addr_s, exp_ar_q.pop_front());
          outstanding++;
        end
        if (r_fire_s) outstanding--;
        if (t_fire_s) begin
          check("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            beat_t b;
            b = exp_q.pop_front();
            check("tdata", bus.m_axis_tdata, b.data);
            check("tlast", bus.m_axis_tlast, b.last);
          end
          t_count++;
        end
        if (prev_tvalid && !prev_tready) begin
          check("tvalid_hold", bus.m_axis_tvalid, 1);
          check("tdata_hold", bus.m_axis_tdata, prev_tdata);
        end
        prev_tvalid = bus.m_axis_tvalid;
        prev_tready = bus.m_axis_tready;
        prev_tdata  = bus.m_axis_tdata;
      end
    end
  end

  // BRAM read-port model and stream consumer, driven just after posedge.
  initial begin
    bus.m_axil_arready = 1'b0;
    bus.m_axil_rvalid  = 1'b0;
    bus.m_axil_rdata   = '0;
    bus.m_axil_rresp   = 2'b00;
    bus.m_axis_tready  = 1'b0;
    forever begin
      @(posedge clka);
      #1;
      if (rstb) begin
        bus.m_axil_arready = 1'b0;
        bus.m_axil_rvalid  = 1'b0;
        rd_q.delete();
      end else begin
        if (ar_fire_s) rd_q.push_back(ar_addr_s);
        if (r_fire_s) begin
          bus.m_axil_rvalid = 1'b0;
          beat_idx++;
        end
        if (!bus.m_axil_rvalid && rd_q.size() > 0 && (mode == 0 || $urandom_range(0, 2) == 0)) begin
          logic [AW-1:0] a;
          a = rd_q.pop_front();
          bus.m_axil_rdata  = mem[a[AW-1:2]];
          bus.m_axil_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
          bus.m_axil_rvalid = 1'b1;
        end
        bus.m_axil_arready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (tready_manual == 0)
        bus.m_axis_tready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_err"},     err, 0);
    check({tag, "_arvalid"}, bus.m_axil_arvalid, 0);
    check({tag, "_rready"},  bus.m_axil_rready, 0);
    check({tag, "_tvalid"},  bus.m_axis_tvalid, 0);
    check({tag, "_tlast"},   bus.m_axis_tlast, 0);
    check({tag, "_araddr"},  bus.m_axil_araddr, 0);
    check({tag, "_tdata"},   bus.m_axis_tdata, 0);
  endtask

  task automatic push_expect(input logic [AW-1:0] base, input int cnt);
    logic [AW-1:0] a;
    beat_t b;
    a = base & ~AW'(3);
    for (int i = 0; i < cnt; i++) begin
      exp_ar_q.push_back(a);
      b.data = mem[a[AW-1:2]];
      b.last = (i == cnt - 1);
      exp_q.push_back(b);
      a = a + AW'(4);
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] base, input int cnt, input int eb, input bit stall);
    int  c0;
    int  stall_seen;
    bit  got;
    logic exp_err;
    @(posedge clka);
    #1;
    beat_idx = 0;
    err_beat = eb;
    if (stall) begin
      tready_manual = 1;
      bus.m_axis_tready = 1'b0;
    end
    start = 1'b1;
    base_addr = base;
    word_count = CW'(cnt);
    push_expect(base, cnt);
    @(posedge clka);
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    word_count = CW'($urandom);
    c0 = cyc;
    got = 0;
    stall_seen = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clka);
      if (k == 0) begin
        check("busy_after_start", busy, cnt != 0);
        check("err_cleared_by_start", err, 0);
        if (cnt == 0) check("empty_no_tvalid", bus.m_axis_tvalid, 0);
      end
      if (done) begin
        got = 1;
        break;
      end
      if (stall && bus.m_axis_tvalid && stall_seen < 10) begin
        stall_seen++;
        check("rready_while_stalled", bus.m_axil_rready, 0);
      end
      @(posedge clka);
      #1;
      if (stall && stall_seen >= 10) bus.m_axis_tready = 1'b1;
      if (mode == 1 && busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        base_addr = AW'($urandom);
        word_count = CW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check("done_seen", got, 1);
    if (got) begin
      check("busy_low_at_done", busy, 0);
      if (mode == 0 && !stall) check("latency", cyc - c0, (cnt == 0) ? 0 : 2 * cnt + 1);
      if (stall) check("stall_length", stall_seen, 10);
      check("beats_drained", exp_q.size(), 0);
      check("ars_drained", exp_ar_q.size(), 0);
`ifdef AXIL_READER_RRESP_CHECK_EN
      exp_err = (eb >= 0 && eb < cnt);
`else
      exp_err = 1'b0;
`endif
      check("err_after_done", err, exp_err);
      @(negedge clka);
      check("done_one_cycle", done, 0);
    end
    tready_manual = 0;
  endtask

  task automatic reset_mid_burst();
    int t0;
    bit reached;
    @(posedge clka);
    #1;
    beat_idx = 0;
    err_beat = -1;
    start = 1'b1;
    base_addr = 9'h000;
    word_count = 8'd8;
    push_expect(9'h000, 8);
    @(posedge clka);
    #1;
    start = 1'b0;
    t0 = t_count;
    reached = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clka);
      if (t_count - t0 >= 2) begin
        reached = 1;
        break;
      end
    end
    check("reach_third_word", reached, 1);
    @(posedge clka);
    #1;
    rstb = 1'b1;
    @(posedge clka);
    @(negedge clka);
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_ar_q.delete();
    outstanding = 0;
    @(posedge clka);
    #1;
    rstb = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(WORDS); i++)
      mem[i] = (i < 8) ? (32'hA0 + 32'(i)) : $urandom();

    repeat (3) @(posedge clka);
    @(negedge clka);
    check_reset_outputs("reset");
    @(posedge clka);
    #1;
    rstb = 1'b0;

    mode = 0;
    run_burst(9'h010, 4, -1, 0);   // words 4..7, 2 cycles per word
    run_burst(9'h020, 0, -1, 0);   // empty burst
    run_burst(9'h1F8, 4, -1, 0);   // address wrap
    run_burst(9'h013, 3, -1, 0);   // unaligned base forced aligned
    run_burst(9'h000, 4, -1, 1);   // stream back-pressure
    reset_mid_burst();
    run_burst(9'h040, 2, -1, 0);
    run_burst(9'h030, 4, 1, 0);    // error response on second beat
    run_burst(9'h030, 3, -1, 0);   // next start clears err

    mode = 1;
    for (int n = 0; n < 40; n++) begin
      int cnt;
      int eb;
      cnt = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
      eb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_burst(AW'($urandom), cnt, eb, 0);
    end
    run_burst(9'h1FC, 3, -1, 1);

    check("final_outstanding", outstanding, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
